// File: rtl/hwpe_stream_narrow_if.sv
// HWPE-Stream handshake bundle: data/strobe with valid/ready.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;

    modport source (output valid, output data, output strb, input ready);
    modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/hwpe_stream_narrow.sv
// Width downsizer: one wide push word becomes RATIO narrow pop beats, lowest slice first.
// Define HWPE_STREAM_NARROW_SKIP_EN to drop beats whose strobe slice is all zero.
module hwpe_stream_narrow #(
    parameter int unsigned DATA_WIDTH_IN = 128,
    parameter int unsigned RATIO         = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    output logic                       busy_o,
    output logic [$clog2(RATIO)-1:0]   beat_o,
    hwpe_stream_intf_stream.sink       push_i,
    hwpe_stream_intf_stream.source     pop_o
);
    localparam int unsigned DW_OUT = DATA_WIDTH_IN / RATIO;
    localparam int unsigned SW_IN  = DATA_WIDTH_IN / 8;
    localparam int unsigned SW_OUT = DW_OUT / 8;
    localparam int unsigned CW     = $clog2(RATIO);

    typedef enum logic {EMPTY, HOLD} state_e;

    state_e                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH_IN-1:0] data_q;
    logic [SW_IN-1:0]         strb_q;
    logic                     full_q, accept, pop_hs, last_beat, first_ok;
    logic [CW-1:0]            first_idx, next_idx;

`ifdef HWPE_STREAM_NARROW_SKIP_EN
    logic next_ok;

    // {found, index} of the lowest slice at or above 'from' with a nonzero strobe
    function automatic logic [CW:0] find_nz(input logic [SW_IN-1:0] s, input int unsigned from);
        logic [CW:0] r;
        r = '0;
        for (int unsigned k = 0; k < RATIO; k++)
            if (!r[CW] && k >= from && |s[k*SW_OUT +: SW_OUT]) r = {1'b1, CW'(k)};
        return r;
    endfunction

    always_comb begin
        {first_ok, first_idx} = find_nz(push_i.strb, 0);
        {next_ok, next_idx}   = find_nz(strb_q, 32'(cnt_q) + 32'd1);
        last_beat             = ~next_ok;
    end
`else
    assign first_ok  = 1'b1;
    assign first_idx = '0;
    assign next_idx  = cnt_q + CW'(1);
    assign last_beat = (cnt_q == CW'(RATIO - 1));
`endif

    assign full_q       = (state_q == HOLD);
    assign pop_hs       = full_q & pop_o.ready;
    assign push_i.ready = ~full_q | (pop_o.ready & last_beat);
    assign accept       = push_i.valid & push_i.ready;

    // accept can only coincide with a pop on the last beat, so it also covers the reload
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            state_d = EMPTY;
            cnt_d   = '0;
        end else if (accept) begin
            state_d = first_ok ? HOLD : EMPTY;
            cnt_d   = first_ok ? first_idx : '0;
        end else if (pop_hs) begin
            if (last_beat) begin
                state_d = EMPTY;
                cnt_d   = '0;
            end else begin
                cnt_d   = next_idx;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            cnt_q   <= '0;
            data_q  <= '0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (clear_i) begin
                data_q <= '0;
                strb_q <= '0;
            end else if (accept) begin
                data_q <= push_i.data;
                strb_q <= push_i.strb;
            end
        end
    end

    always_comb begin
        pop_o.valid = full_q;
        pop_o.data  = '0;
        pop_o.strb  = '0;
        if (full_q) begin
            pop_o.data = data_q[cnt_q*DW_OUT +: DW_OUT];
            pop_o.strb = strb_q[cnt_q*SW_OUT +: SW_OUT];
        end
    end

    assign busy_o = full_q;
    assign beat_o = cnt_q;
endmodule

// File: tb/tb_hwpe_stream_narrow.sv
// Scoreboard bench for hwpe_stream_narrow (128 -> 4 x 32).
module tb_hwpe_stream_narrow;
    localparam int unsigned DWI = 128;
    localparam int unsigned R   = 4;
    localparam int unsigned DWO = DWI / R;

    typedef struct {
        logic [DWO-1:0]   data;
        logic [DWO/8-1:0] strb;
        logic [1:0]       idx;
    } beat_t;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic clear_i = 1'b0;
    logic busy_o;
    logic [1:0] beat_o;

    hwpe_stream_intf_stream #(.DATA_WIDTH(DWI)) push ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(DWO)) pop ();

    hwpe_stream_narrow #(.DATA_WIDTH_IN(DWI), .RATIO(R)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i),
        .busy_o(busy_o), .beat_o(beat_o),
        .push_i(push), .pop_o(pop)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    beat_t sb[$];
    int pops = 0;
    bit mon_b2b = 0;
    int beats2 = 0, gaps2 = 0, rdy2 = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference split of one accepted word into expected beats
    task automatic expect_word(input logic [DWI-1:0] d, input logic [DWI/8-1:0] s);
        beat_t b;
        for (int i = 0; i < R; i++) begin
            b.data = d[i*DWO +: DWO];
            b.strb = s[i*(DWO/8) +: DWO/8];
            b.idx  = 2'(i);
`ifdef HWPE_STREAM_NARROW_SKIP_EN
            if (b.strb == '0) continue;
`endif
            sb.push_back(b);
        end
    endtask

    // Sample mid-cycle: what is seen here is what the next rising edge consumes
    always @(negedge clk) begin
        if (rst_ni) begin
            if (pop.valid && pop.ready) begin
                pops++;
                check_eq("sb_nonempty", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    beat_t e;
                    e = sb.pop_front();
                    check_eq("pop_data", 64'(pop.data), 64'(e.data));
                    check_eq("pop_strb", 64'(pop.strb), 64'(e.strb));
                    check_eq("beat_o", 64'(beat_o), 64'(e.idx));
                end
            end
            if (push.valid && push.ready && !clear_i) expect_word(push.data, push.strb);
            if (mon_b2b) begin
                if (pop.valid) begin
                    if (pop.ready) beats2++;
                    if (push.ready) rdy2++;
                end else if (beats2 > 0 && beats2 < 12) gaps2++;
            end
        end
    end

    task automatic send(input logic [DWI-1:0] d, input logic [DWI/8-1:0] s);
        bit acc = 0;
        push.valid = 1'b1;
        push.data  = d;
        push.strb  = s;
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            acc = push.ready;
            @(posedge clk);
            #1;
        end
        check_eq("accept_timeout", 64'(acc), 64'd1);
    endtask

    task automatic drain(output int cyc);
        cyc = 0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (sb.size() == 0 && !pop.valid) break;
        end
        check_eq("drain_left", 64'(sb.size()), 64'd0);
        check_eq("drain_busy", 64'(busy_o), 64'd0);
    endtask

    function automatic logic [DWI-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [DWI-1:0] w0;
    int cyc, p0;

    initial begin
        push.valid = 1'b0;
        push.data  = '0;
        push.strb  = '0;
        pop.ready  = 1'b1;
        w0 = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        #12;
        check_eq("rst_valid", 64'(pop.valid), 64'd0);
        check_eq("rst_data", 64'(pop.data), 64'd0);
        check_eq("rst_strb", 64'(pop.strb), 64'd0);
        check_eq("rst_busy", 64'(busy_o), 64'd0);
        check_eq("rst_beat", 64'(beat_o), 64'd0);
        check_eq("rst_ready", 64'(push.ready), 64'd1);
        @(posedge clk); #1;
        rst_ni = 1'b1;
        @(posedge clk); #1;

        // single word, first beat one cycle after accept
        p0 = pops;
        send(w0, 16'hFFFF);
        push.valid = 1'b0;
        check_eq("lat_valid", 64'(pop.valid), 64'd1);
        check_eq("lat_data", 64'(pop.data), 64'h11111111);
        drain(cyc);
        check_eq("single_cycles", 64'(cyc), 64'd4);
        check_eq("single_pops", 64'(pops - p0), 64'd4);

        // back-to-back words
        beats2 = 0; gaps2 = 0; rdy2 = 0;
        mon_b2b = 1;
        for (int i = 0; i < 3; i++) send(rnd_word(), 16'hFFFF);
        push.valid = 1'b0;
        drain(cyc);
        mon_b2b = 0;
        check_eq("b2b_beats", 64'(beats2), 64'd12);
        check_eq("b2b_gaps", 64'(gaps2), 64'd0);
        check_eq("b2b_ready_cnt", 64'(rdy2), 64'd3);

        // backpressure at beat 2
        p0 = pops;
        pop.ready = 1'b0;
        send(w0, 16'hFFFF);
        push.valid = 1'b0;
        pop.ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        pop.ready = 1'b0;
        push.valid = 1'b1;
        push.data  = rnd_word();
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_data", 64'(pop.data), 64'h33333333);
            check_eq("bp_beat", 64'(beat_o), 64'd2);
            check_eq("bp_valid", 64'(pop.valid), 64'd1);
            check_eq("bp_ready", 64'(push.ready), 64'd0);
            @(posedge clk); #1;
            push.data = rnd_word();
        end
        push.valid = 1'b0;
        pop.ready = 1'b1;
        drain(cyc);
        check_eq("bp_pops", 64'(pops - p0), 64'd4);

        // asynchronous reset at beat 1
        send(w0, 16'hFFFF);
        push.valid = 1'b0;
        @(posedge clk); #1;
        check_eq("rm_beat", 64'(beat_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        check_eq("rm_valid", 64'(pop.valid), 64'd0);
        check_eq("rm_ready", 64'(push.ready), 64'd1);
        check_eq("rm_beat0", 64'(beat_o), 64'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_ni = 1'b1;
        send(w0, 16'hFFFF);
        push.valid = 1'b0;
        check_eq("rm_restart_beat", 64'(beat_o), 64'd0);
        check_eq("rm_restart_data", 64'(pop.data), 64'h11111111);
        drain(cyc);

        // clear together with a push: word not stored
        push.valid = 1'b1;
        push.data  = rnd_word();
        push.strb  = 16'hFFFF;
        clear_i = 1'b1;
        @(posedge clk); #1;
        clear_i = 1'b0;
        push.valid = 1'b0;
        check_eq("clr_push_valid", 64'(pop.valid), 64'd0);

        // clear mid-word
        send(w0, 16'hFFFF);
        push.valid = 1'b0;
        @(posedge clk); #1;
        clear_i = 1'b1;
        check_eq("clr_sync_hold", 64'(pop.valid), 64'd1);
        @(posedge clk); #1;
        clear_i = 1'b0;
        check_eq("clr_valid", 64'(pop.valid), 64'd0);
        check_eq("clr_beat", 64'(beat_o), 64'd0);
        sb.delete();

        // sparse strobe: zero slices emitted without the skip feature, dropped with it
        p0 = pops;
        send(w0, 16'hF0F0);
        push.valid = 1'b0;
        drain(cyc);
`ifdef HWPE_STREAM_NARROW_SKIP_EN
        check_eq("sparse_pops", 64'(pops - p0), 64'd2);
`else
        check_eq("sparse_pops", 64'(pops - p0), 64'd4);
`endif

        // all-zero strobe
        p0 = pops;
        send(rnd_word(), 16'h0000);
        push.valid = 1'b0;
`ifdef HWPE_STREAM_NARROW_SKIP_EN
        check_eq("zero_ready", 64'(push.ready), 64'd1);
        check_eq("zero_valid", 64'(pop.valid), 64'd0);
`else
        check_eq("zero_ready", 64'(push.ready), 64'd0);
        check_eq("zero_valid", 64'(pop.valid), 64'd1);
`endif
        drain(cyc);
`ifdef HWPE_STREAM_NARROW_SKIP_EN
        check_eq("zero_pops", 64'(pops - p0), 64'd0);
`else
        check_eq("zero_pops", 64'(pops - p0), 64'd4);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hwpe_stream_narrow.md
# hwpe_stream_narrow

Downstream width-downsizing stage for HWPE-Stream FIFOs: accepts one wide word per handshake on `push_i` and emits it as `RATIO` narrower beats on `pop_o`, lowest slice first. It sits directly after a wide FIFO, between a wide memory-side streamer and a narrow datapath. Data and strobe are split consistently, and the stage sustains full output throughput with no bubble between consecutive wide words.

## Interface
- `DATA_WIDTH_IN`, default 128: width of the `push_i` data. Must be a multiple of `8*RATIO`.
- `RATIO`, default 4: number of output beats per input word. Power of two, at least 2.
- Derived: `DATA_WIDTH_OUT = DATA_WIDTH_IN/RATIO`; strobe widths are `DATA_WIDTH_IN/8` and `DATA_WIDTH_OUT/8`.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `clear_i`  in  1  synchronous clear; same effect as reset and takes priority over all activity.
- `busy_o`  out  1  high while a word is held.
- `beat_o`  out  `$clog2(RATIO)`  index of the slice currently on `pop_o`.
- `push_i`  sink  `DATA_WIDTH_IN`  wide input stream (`data`, `strb`, `valid`, `ready`).
- `pop_o`  source  `DATA_WIDTH_OUT`  narrow output stream.

## Operation
- The stage holds one wide word: a data/strobe register, `full_q`, and a beat counter `cnt_q`.
- There are two states:
  - **EMPTY**: `full_q=0`.
  - **HOLD**: `full_q=1`.
- Accept condition: `push_i.valid & push_i.ready`. On accept, the word is latched, `full_q` is set to 1, and `cnt_q` is set to the first beat index (0 without the skip feature).
- Output slice k carries `data[k*DATA_WIDTH_OUT +: DATA_WIDTH_OUT]` and `strb[k*DATA_WIDTH_OUT/8 +: DATA_WIDTH_OUT/8]`.
- `pop_o.valid = full_q`. When `pop_o.valid=0`, `pop_o.data` and `pop_o.strb` are driven to 0.
- On a pop handshake, one of two things happens:
  - **Not the last beat**: `cnt_q` advances to the next beat index.
  - **Last beat**: the stage returns to EMPTY, or, if a new word is accepted in the same cycle, reloads and stays in HOLD.
- `push_i.ready = ~full_q | (pop_o.ready & last_beat)`. This is combinational from `pop_o.ready`; there is no combinational path from `push_i.valid` to `pop_o`.
- `last_beat` is defined as `cnt_q == RATIO-1` without the skip feature.
- `beat_o = cnt_q`. `busy_o = full_q`.
- If `push_i` data changes while `valid=1` and `ready=0`, there is no effect.

## Timing
- Reset and clear values:
  - `full_q=0`, `cnt_q=0`, data/strb registers 0.
  - Outputs: `pop_o.valid=0`, `pop_o.data=0`, `pop_o.strb=0`, `busy_o=0`, `beat_o=0`.
  - `push_i.ready=1`.
- Latency: the first beat is valid on `pop_o` in the cycle after the accept edge.
- Throughput: one beat per cycle while `pop_o.ready=1`. A new word is accepted on the cycle its predecessor's last beat pops, so there are no idle cycles.
- Backpressure: with `pop_o.ready=0`, the current slice, `beat_o`, and `valid` stay stable, and `push_i.ready=0` while HOLD.
- Reset asserted mid-word: the held word is discarded immediately (asynchronous). `clear_i` discards it at the next edge.
- When `clear_i=1` and `push_i.valid=1` in the same cycle, the word is not stored, although `ready` may read 1.

## Configuration
- `HWPE_STREAM_NARROW_SKIP_EN` **undefined**: all `RATIO` beats are always emitted, in order 0..RATIO-1, including beats whose strobe slice is all zero.
- `HWPE_STREAM_NARROW_SKIP_EN` **defined**: beats whose strobe slice is all zero are skipped.
  - `cnt_q` loads and advances to the next index with a nonzero strobe slice; `last_beat` means there is no nonzero slice above `cnt_q`.
  - A word whose entire strobe is zero is consumed on accept with no output beat: `full_q` stays 0 and `push_i.ready` stays 1.
  - Beats that are emitted keep ascending order.

## Test plan
With `DATA_WIDTH_IN=128`, `RATIO=4`:
- **Single word**: push data `0x44444444_33333333_22222222_11111111`, strb `0xFFFF`, `pop_o.ready=1`. Pop beats `0x11111111`, `0x22222222`, `0x33333333`, `0x44444444` with strb `0xF`, on cycles 1-4 after accept; `busy_o` falls after beat 4.
- **Back-to-back**: 3 words pushed continuously, `pop_o.ready=1`. 12 consecutive beats with no gap; `push_i.ready` is high only on the accept cycle and on the last-beat cycles.
- **Backpressure**: `pop_o.ready=0` for 5 cycles at beat 2. `pop_o.data` is held at `0x33333333`, `beat_o=2`, `push_i.ready=0`; the stream resumes with no beat lost or duplicated.
- **Reset mid-word**: assert `rst_ni=0` at beat 1. `pop_o.valid` drops to 0 immediately and `push_i.ready=1`; the next word starts again at beat 0.
- **Skip (macro defined)**: strb `0xF0F0`. Only beats 1 and 3 are emitted, values `0x22222222` and `0x44444444`. Strb `0x0000` produces no output and `ready` remains 1.
- **Skip off (macro undefined)**: strb `0xF0F0`. Four beats are emitted, with strb `0x0`, `0xF`, `0x0`, `0xF`.
